// File: rtl/aqm_pkg.sv
// Shared types and width helper for the activity quorum monitor.
package aqm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    GRACE = 2'd2,
    FAIL  = 2'd3
  } aqm_state_e;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/aqm_popcount.sv
// Combinational population count of an N-bit vector.
module aqm_popcount #(
  parameter int N = 2
) (
  input  logic [N-1:0]           sig,
  output logic [$clog2(N+1)-1:0] cnt
);
  import aqm_pkg::*;

  localparam int W = cnt_w(N);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++)
      cnt = cnt + W'(sig[i]);
  end

endmodule

// File: rtl/activity_quorum_monitor.sv
// Quorum checker: at least MIN_ACTIVE of N bits high, GRACE misses tolerated.
// Define AQM_SNAPSHOT_EN to add the snap/snap_valid capture outputs.
module activity_quorum_monitor #(
  parameter int N          = 2,
  parameter int MIN_ACTIVE = 1,
  parameter int GRACE      = 0,
  parameter int CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic [N-1:0]           sig,
  output logic                   err_pulse,
  output logic                   err_sticky,
  output logic [CNT_W-1:0]       viol_cnt,
  output logic [$clog2(N+1)-1:0] active_cnt,
  output logic [1:0]             state_o
`ifdef AQM_SNAPSHOT_EN
  ,
  output logic [N-1:0]           snap,
  output logic                   snap_valid
`endif
);
  import aqm_pkg::*;

  localparam int AW = cnt_w(N);
  localparam int RW = (GRACE < 1) ? 1 : cnt_w(GRACE);

  logic [AW-1:0] pop;
  logic          pass;
  logic          violate;
  aqm_state_e    state, state_n;
  logic [RW-1:0] run_cnt, run_n;

  aqm_popcount #(.N(N)) u_pop (
    .sig (sig),
    .cnt (pop)
  );

  assign pass    = (pop >= AW'(MIN_ACTIVE));
  assign state_o = state;

  always_comb begin
    state_n = state;
    run_n   = run_cnt;
    violate = 1'b0;
    if (!en) begin
      state_n = IDLE;
      run_n   = '0;
    end else begin
      case (state)
        IDLE: state_n = ARMED;
        ARMED: begin
          if (!pass) begin
            if (GRACE == 0) begin
              state_n = FAIL;
              violate = 1'b1;
            end else begin
              state_n = aqm_pkg::GRACE;
              run_n   = RW'(1);
            end
          end
        end
        aqm_pkg::GRACE: begin
          if (pass) begin
            state_n = ARMED;
            run_n   = '0;
          end else if (run_cnt == RW'(GRACE)) begin
            state_n = FAIL;
            run_n   = '0;
            violate = 1'b1;
          end else begin
            run_n = run_cnt + RW'(1);
          end
        end
        FAIL: if (pass) state_n = ARMED;
        default: state_n = IDLE;
      endcase
    end
  end

  // A violation in the same cycle as clr takes priority over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      run_cnt    <= '0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      viol_cnt   <= '0;
      active_cnt <= '0;
    end else begin
      state      <= state_n;
      run_cnt    <= run_n;
      active_cnt <= pop;
      err_pulse  <= violate;
      if (violate)
        err_sticky <= 1'b1;
      else if (clr)
        err_sticky <= 1'b0;
      if (clr)
        viol_cnt <= violate ? CNT_W'(1) : '0;
      else if (violate && (viol_cnt != '1))
        viol_cnt <= viol_cnt + CNT_W'(1);
    end
  end

`ifdef AQM_SNAPSHOT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      snap       <= '0;
      snap_valid <= 1'b0;
    end else if (violate) begin
      snap       <= sig;
      snap_valid <= 1'b1;
    end else if (clr) begin
      snap       <= '0;
      snap_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_activity_quorum_monitor.sv
// Scoreboard bench for activity_quorum_monitor with a behavioural model.
module tb_activity_quorum_monitor;
  localparam int N          = 4;
  localparam int MIN_ACTIVE = 2;
  localparam int GRACE      = 2;
  localparam int CNT_W      = 2;
  localparam int MAXC       = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst, en, clr;
  logic [N-1:0]           sig;
  logic                   err_pulse, err_sticky;
  logic [CNT_W-1:0]       viol_cnt;
  logic [$clog2(N+1)-1:0] active_cnt;
  logic [1:0]             state_o;
`ifdef AQM_SNAPSHOT_EN
  logic [N-1:0]           snap;
  logic                   snap_valid;
`endif

  always #5 clk = ~clk;

  activity_quorum_monitor #(
    .N(N), .MIN_ACTIVE(MIN_ACTIVE), .GRACE(GRACE), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .sig        (sig),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .viol_cnt   (viol_cnt),
    .active_cnt (active_cnt),
    .state_o    (state_o)
`ifdef AQM_SNAPSHOT_EN
    ,
    .snap       (snap),
    .snap_valid (snap_valid)
`endif
  );

  typedef struct {
    int pulse, sticky, cnt, act, st, snp, sv;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  // Model: "armed" after one enabled sample; a run of misses counted.
  int m_armed, m_fails, m_failed, m_sticky, m_cnt, m_snap, m_sv;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic c,
                      input logic [N-1:0] s);
    exp_t x;
    int   viol;
    @(negedge clk);
    rst = r; en = e; clr = c; sig = s;
    viol = 0;
    if (r) begin
      m_armed = 0; m_fails = 0; m_failed = 0;
      m_sticky = 0; m_cnt = 0; m_snap = 0; m_sv = 0;
    end else begin
      if (!e) begin
        m_armed = 0; m_fails = 0; m_failed = 0;
      end else if (m_armed == 0) begin
        m_armed = 1;
      end else if ($countones(s) >= MIN_ACTIVE) begin
        m_fails = 0; m_failed = 0;
      end else begin
        m_fails++;
        if (m_failed == 0 && m_fails == GRACE + 1) begin
          viol = 1; m_failed = 1;
        end
      end
      if (c) begin
        m_sticky = 0; m_cnt = 0; m_snap = 0; m_sv = 0;
      end
      if (viol != 0) begin
        m_sticky = 1;
        m_cnt    = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
        m_snap   = int'(s);
        m_sv     = 1;
      end
    end
    x.pulse  = viol;
    x.sticky = m_sticky;
    x.cnt    = m_cnt;
    x.act    = r ? 0 : $countones(s);
    x.st     = (m_armed == 0) ? 0 : (m_failed != 0) ? 3 : (m_fails > 0) ? 2 : 1;
    x.snp    = m_snap;
    x.sv     = m_sv;
    q.push_back(x);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("err_pulse", int'(err_pulse), x.pulse);
        chk("err_sticky", int'(err_sticky), x.sticky);
        chk("viol_cnt", int'(viol_cnt), x.cnt);
        chk("active_cnt", int'(active_cnt), x.act);
        chk("state_o", int'(state_o), x.st);
`ifdef AQM_SNAPSHOT_EN
        chk("snap", int'(snap), x.snp);
        chk("snap_valid", int'(snap_valid), x.sv);
`endif
      end
    end
  end

  initial begin
    logic [N-1:0] s;
    step(1, 0, 0, 4'b0000);
    step(1, 0, 0, 4'b1111);
    step(0, 1, 0, 4'b0011);
    step(0, 1, 0, 4'b0101);
    repeat (3) step(0, 1, 0, 4'b0000);
    repeat (5) step(0, 1, 0, 4'b0000);
    step(0, 1, 0, 4'b0011);
    step(0, 1, 0, 4'b0000);
    step(0, 1, 0, 4'b0000);
    step(0, 1, 0, 4'b1010);
    step(0, 1, 0, 4'b0000);
    step(0, 1, 0, 4'b0000);
    step(0, 1, 0, 4'b0100);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 4'b1100);
      repeat (3) step(0, 1, 0, 4'b1000);
    end
    step(0, 1, 1, 4'b0110);
    step(0, 1, 0, 4'b0000);
    step(0, 1, 0, 4'b0000);
    step(0, 1, 1, 4'b0010);
    step(0, 1, 1, 4'b0111);
    step(0, 1, 0, 4'b0000);
    step(1, 1, 0, 4'b0000);
    step(0, 1, 0, 4'b0011);
    repeat (3) step(0, 1, 0, 4'b0001);
    step(0, 0, 0, 4'b0000);
    step(0, 0, 0, 4'b1111);
    for (int i = 0; i < 3000; i++) begin
      s = N'($urandom & $urandom);
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 15) != 0),
           ($urandom_range(0, 15) == 0),
           s);
    end
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
